// File: rtl/demux_vc_param.sv
// Virtual-channel demux with a one-word hold stage, per-VC backpressure and error pulses.
// Optional per-VC delivery / drop statistics are enabled with DEMUX_VC_STATS_EN.
module demux_vc_param #(
  parameter int BW      = 6,
  parameter int NUM_VC  = 2,
  parameter int SEL_LSB = 5,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [BW-1:0]        data_in,
  input  logic [NUM_VC-1:0]    vc_pause,
  output logic                 in_pause,
  output logic [NUM_VC*BW-1:0] data_out,
  output logic [NUM_VC-1:0]    valid_out,
  output logic                 err_bad_vc,
  output logic                 err_overflow,
  output logic                 dbg_state
`ifdef DEMUX_VC_STATS_EN
  ,
  output logic [NUM_VC*CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0]        drop_count
`endif
);

  localparam int SEL_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int NSEL  = 1 << SEL_W;

  // Handshake: upstream may assert valid_in only while in_pause=0; a word that
  // arrives while in_pause=1 is dropped and flagged. Downstream vc_pause[k]=1
  // means VC k must not receive a push in the next cycle.

  if (NUM_VC < 2) begin : g_bad_num_vc
    $error("demux_vc_param: NUM_VC must be >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux_vc_param: CNT_W must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [BW-1:0]     r_hold_data;
  logic [SEL_W-1:0]  r_hold_sel;

  logic [SEL_W-1:0]  w_sel;
  logic [NSEL-1:0]   w_pause_ext;
  logic              w_sel_bad;
  logic              w_push;
  logic [SEL_W-1:0]  w_push_sel;
  logic [BW-1:0]     w_push_data;
  logic              w_store;
  logic              w_bad;
  logic              w_ovf;

  logic [NUM_VC*BW-1:0] r_data_out;
  logic [NUM_VC-1:0]    r_valid_out;
  logic                 r_err_bad_vc;
  logic                 r_err_overflow;

  assign w_sel     = data_in[SEL_LSB +: SEL_W];
  assign w_sel_bad = ({1'b0, w_sel} >= (SEL_W+1)'(NUM_VC));

  // Pad the pause vector to the full ID range so any field value indexes safely.
  always_comb begin
    w_pause_ext = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      w_pause_ext[k] = vc_pause[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_push_sel   = '0;
    w_push_data  = '0;
    w_store      = 1'b0;
    w_bad        = 1'b0;
    w_ovf        = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          if (w_sel_bad) begin
            w_bad = 1'b1;
          end else if (!w_pause_ext[w_sel]) begin
            w_push      = 1'b1;
            w_push_sel  = w_sel;
            w_push_data = data_in;
          end else begin
            w_store      = 1'b1;
            w_next_state = HOLD;
          end
        end
      end
      HOLD: begin
        // Release has priority; a word arriving in the same cycle is still dropped.
        if (!w_pause_ext[r_hold_sel]) begin
          w_push       = 1'b1;
          w_push_sel   = r_hold_sel;
          w_push_data  = r_hold_data;
          w_next_state = IDLE;
        end
        if (valid_in) begin
          w_ovf = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_data    <= '0;
      r_hold_sel     <= '0;
      r_data_out     <= '0;
      r_valid_out    <= '0;
      r_err_bad_vc   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_hold_data <= data_in;
        r_hold_sel  <= w_sel;
      end
      for (int k = 0; k < NUM_VC; k++) begin
        r_valid_out[k] <= w_push && (w_push_sel == SEL_W'(k));
        if (w_push && (w_push_sel == SEL_W'(k))) begin
          r_data_out[k*BW +: BW] <= w_push_data;
        end
      end
      r_err_bad_vc   <= w_bad;
      r_err_overflow <= w_ovf;
    end
  end

  assign in_pause     = (r_state == HOLD);
  assign dbg_state    = r_state;
  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;
  assign err_bad_vc   = r_err_bad_vc;
  assign err_overflow = r_err_overflow;

`ifdef DEMUX_VC_STATS_EN
  logic [NUM_VC*CNT_W-1:0] r_pkt_count;
  logic [CNT_W-1:0]        r_drop_count;

  // Counters saturate at all-ones and advance on the same edge as their pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      for (int k = 0; k < NUM_VC; k++) begin
        if (w_push && (w_push_sel == SEL_W'(k)) &&
            (r_pkt_count[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          r_pkt_count[k*CNT_W +: CNT_W] <= r_pkt_count[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      if ((w_bad || w_ovf) && (r_drop_count != {CNT_W{1'b1}})) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_demux_vc_param.sv
// Directed bench for demux_vc_param: a 2-VC instance (BW=6, SEL_LSB=5, CNT_W=2)
// and a 3-VC instance (BW=6, SEL_LSB=4) for the out-of-range VC-ID case.
module tb_demux_vc_param;

  logic        clk;
  logic        reset;

  logic        valid_in;
  logic [5:0]  data_in;
  logic [1:0]  vc_pause;
  logic        in_pause;
  logic [11:0] data_out;
  logic [1:0]  valid_out;
  logic        err_bad_vc;
  logic        err_overflow;
  logic        dbg_state;

  logic        valid1_in;
  logic [5:0]  data1_in;
  logic [2:0]  vc1_pause;
  logic        in1_pause;
  logic [17:0] data1_out;
  logic [2:0]  valid1_out;
  logic        err1_bad_vc;
  logic        err1_overflow;
  logic        dbg1_state;

`ifdef DEMUX_VC_STATS_EN
  logic [3:0]  pkt_count;
  logic [1:0]  drop_count;
  logic [5:0]  pkt1_count;
  logic [1:0]  drop1_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  demux_vc_param #(.BW(6), .NUM_VC(2), .SEL_LSB(5), .CNT_W(2)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .vc_pause     (vc_pause),
    .in_pause     (in_pause),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .err_bad_vc   (err_bad_vc),
    .err_overflow (err_overflow),
    .dbg_state    (dbg_state)
`ifdef DEMUX_VC_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .drop_count   (drop_count)
`endif
  );

  demux_vc_param #(.BW(6), .NUM_VC(3), .SEL_LSB(4), .CNT_W(2)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid1_in),
    .data_in      (data1_in),
    .vc_pause     (vc1_pause),
    .in_pause     (in1_pause),
    .data_out     (data1_out),
    .valid_out    (valid1_out),
    .err_bad_vc   (err1_bad_vc),
    .err_overflow (err1_overflow),
    .dbg_state    (dbg1_state)
`ifdef DEMUX_VC_STATS_EN
    ,
    .pkt_count    (pkt1_count),
    .drop_count   (drop1_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0; data_in = '0; vc_pause = '0;
    valid1_in = 1'b0; data1_in = '0; vc1_pause = '0;
    #2;
    n_tests++;
    if (in_pause !== 1'b0 || valid_out !== 2'b00 || data_out !== 12'h000 ||
        err_bad_vc !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: in_pause=%b valid_out=%b data_out=%h errs=%b%b, want 0 0 000 00",
               in_pause, valid_out, data_out, err_bad_vc, err_overflow);
    end
    step();
    step();
    reset = 1'b0;
    step();
    n_tests++;
    if (in_pause !== 1'b0 || valid_out !== 2'b00 || valid1_out !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: in_pause=%b valid_out=%b valid1_out=%b, want 0 00 000",
               in_pause, valid_out, valid1_out);
    end
`ifdef DEMUX_VC_STATS_EN
    n_tests++;
    if (pkt_count !== 4'h0 || drop_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_stats: pkt_count=%h drop_count=%0d, want 0 0", pkt_count, drop_count);
    end
`endif
  endtask

  task automatic test_basic_route();
    valid_in = 1'b1; data_in = 6'h05; vc_pause = 2'b00;
    step();
    data_in = 6'h25;
    n_tests++;
    if (valid_out !== 2'b01 || data_out[5:0] !== 6'h05) begin
      n_fail++;
      $display("FAIL route_vc0: valid_out=%b data=%h, want 01 05", valid_out, data_out[5:0]);
    end
    step();
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 2'b10 || data_out[11:6] !== 6'h25 || data_out[5:0] !== 6'h05) begin
      n_fail++;
      $display("FAIL route_vc1: valid_out=%b data=%h, want 10 and 25/05", valid_out, data_out);
    end
    step();
    n_tests++;
    if (valid_out !== 2'b00 || data_out !== 12'h945) begin
      n_fail++;
      $display("FAIL route_idle: valid_out=%b data_out=%h, want 00 945", valid_out, data_out);
    end
    // A pause on the other VC must not stall traffic to VC0.
    valid_in = 1'b1; data_in = 6'h04; vc_pause = 2'b10;
    step();
    valid_in = 1'b0; vc_pause = 2'b00;
    n_tests++;
    if (valid_out !== 2'b01 || data_out[5:0] !== 6'h04 || in_pause !== 1'b0) begin
      n_fail++;
      $display("FAIL other_vc_pause: valid_out=%b data=%h in_pause=%b, want 01 04 0",
               valid_out, data_out[5:0], in_pause);
    end
  endtask

  task automatic test_hold_release();
    vc_pause = 2'b01; valid_in = 1'b1; data_in = 6'h03;
    step();
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 2'b00 || in_pause !== 1'b1 || dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_enter: valid_out=%b in_pause=%b state=%b, want 00 1 1",
               valid_out, in_pause, dbg_state);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (valid_out !== 2'b00 || in_pause !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_wait%0d: valid_out=%b in_pause=%b, want 00 1", i, valid_out, in_pause);
      end
    end
    vc_pause = 2'b00;
    step();
    n_tests++;
    if (valid_out !== 2'b01 || data_out[5:0] !== 6'h03 || in_pause !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid_out=%b data=%h in_pause=%b, want 01 03 0",
               valid_out, data_out[5:0], in_pause);
    end
  endtask

  task automatic test_overflow();
    vc_pause = 2'b01; valid_in = 1'b1; data_in = 6'h03;
    step();
    data_in = 6'h21;
    step();
    valid_in = 1'b0;
    n_tests++;
    if (err_overflow !== 1'b1 || valid_out !== 2'b00 || data_out[11:6] !== 6'h25) begin
      n_fail++;
      $display("FAIL overflow_pulse: err=%b valid_out=%b vc1=%h, want 1 00 25",
               err_overflow, valid_out, data_out[11:6]);
    end
    step();
    n_tests++;
    if (err_overflow !== 1'b0 || in_pause !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_once: err=%b in_pause=%b, want 0 1", err_overflow, in_pause);
    end
`ifdef DEMUX_VC_STATS_EN
    n_tests++;
    if (drop_count !== 2'd1) begin
      n_fail++;
      $display("FAIL overflow_drop_count: got %0d want 1", drop_count);
    end
`endif
    // Release and a new word in the same cycle: release wins, the new word is dropped.
    vc_pause = 2'b00; valid_in = 1'b1; data_in = 6'h22;
    step();
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 2'b01 || data_out !== 12'h943 || err_overflow !== 1'b1 || in_pause !== 1'b0) begin
      n_fail++;
      $display("FAIL release_and_ovf: valid_out=%b data_out=%h err=%b in_pause=%b, want 01 943 1 0",
               valid_out, data_out, err_overflow, in_pause);
    end
  endtask

  task automatic test_back_to_back();
    vc_pause = 2'b10; valid_in = 1'b1; data_in = 6'h2a;
    step();
    valid_in = 1'b0;
    step();
    // Release, then accept a new word the very cycle in_pause drops.
    vc_pause = 2'b00;
    step();
    n_tests++;
    if (valid_out !== 2'b10 || data_out[11:6] !== 6'h2a || in_pause !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release: valid_out=%b vc1=%h in_pause=%b, want 10 2a 0",
               valid_out, data_out[11:6], in_pause);
    end
    valid_in = 1'b1; data_in = 6'h11;
    step();
    valid_in = 1'b0;
    n_tests++;
    if (valid_out !== 2'b01 || data_out[5:0] !== 6'h11 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: valid_out=%b vc0=%h err=%b, want 01 11 0",
               valid_out, data_out[5:0], err_overflow);
    end
  endtask

  task automatic test_bad_vc();
    valid1_in = 1'b1; data1_in = 6'h30; vc1_pause = 3'b000;
    step();
    data1_in = 6'h20;
    n_tests++;
    if (err1_bad_vc !== 1'b1 || valid1_out !== 3'b000) begin
      n_fail++;
      $display("FAIL bad_vc_pulse: err=%b valid_out=%b, want 1 000", err1_bad_vc, valid1_out);
    end
    step();
    valid1_in = 1'b0;
    n_tests++;
    if (err1_bad_vc !== 1'b0 || valid1_out !== 3'b100 || data1_out !== 18'h20000) begin
      n_fail++;
      $display("FAIL bad_vc_then_vc2: err=%b valid_out=%b data=%h, want 0 100 20000",
               err1_bad_vc, valid1_out, data1_out);
    end
`ifdef DEMUX_VC_STATS_EN
    n_tests++;
    if (drop1_count !== 2'd1 || pkt1_count !== 6'b010000) begin
      n_fail++;
      $display("FAIL bad_vc_stats: drop=%0d pkt=%b, want 1 010000", drop1_count, pkt1_count);
    end
`endif
  endtask

  task automatic test_reset_in_hold();
    vc_pause = 2'b01; valid_in = 1'b1; data_in = 6'h07;
    step();
    valid_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (in_pause !== 1'b0 || valid_out !== 2'b00 || data_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_in_hold: in_pause=%b valid_out=%b data_out=%h, want 0 00 000",
               in_pause, valid_out, data_out);
    end
    step();
    reset = 1'b0;
    vc_pause = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (valid_out !== 2'b00 || data_out !== 12'h000 || in_pause !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_emit%0d: valid_out=%b data_out=%h in_pause=%b, want 00 000 0",
                 i, valid_out, data_out, in_pause);
      end
    end
  endtask

`ifdef DEMUX_VC_STATS_EN
  task automatic test_stats_saturate();
    logic [1:0] exp_cnt;
    valid_in = 1'b1; data_in = 6'h01; vc_pause = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_tests++;
      if (pkt_count[1:0] !== exp_cnt || pkt_count[3:2] !== 2'd0) begin
        n_fail++;
        $display("FAIL stats_sat%0d: pkt_count=%b, want vc1=00 vc0=%b", i, pkt_count, exp_cnt);
      end
    end
    valid_in = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_route();
    test_hold_release();
    test_overflow();
    test_back_to_back();
    test_bad_vc();
    test_reset_in_hold();
`ifdef DEMUX_VC_STATS_EN
    test_stats_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
